// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight GPR writes, forwards operands, raises load-use and mult/div stalls.
// Latency: forwarding is combinational (0 cycles); records advance one stage per non-frozen cycle.
// Backpressure: freeze (ext_hold | md_busy) holds all records and refuses issue; load-use holds ID and bubbles EX.
module hazard_scoreboard #(
    parameter int DATA_W           = 32,
    parameter int REG_ADDR_W       = 5,
    parameter int NUM_RD_PORTS     = 2,
    parameter int FWD_STAGES       = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int MD_LAT           = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             issue_valid,
    input  logic                             issue_we,
    input  logic [REG_ADDR_W-1:0]            issue_waddr,
    input  logic                             issue_load,
    input  logic                             issue_md,
    input  logic                             flush,
    input  logic                             ext_hold,
    input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD_PORTS*DATA_W-1:0]   rf_rdata,
    input  logic [FWD_STAGES*DATA_W-1:0]     stage_wdata,
    output logic [NUM_RD_PORTS*DATA_W-1:0]   fwd_rdata,
    output logic                             stallreq,
    output logic                             bubble_ex,
    output logic                             freeze,
    output logic                             md_busy,
    output logic [31:0]                      stall_cnt
);

    localparam int MD_W = $clog2(MD_LAT + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);

    // Per-stage in-flight write records; index 0 is EX (youngest).
    logic [FWD_STAGES-1:0]   v_q, v_d;
    logic [FWD_STAGES-1:0]   we_q, we_d;
    logic [FWD_STAGES-1:0]   load_q, load_d;
    logic [REG_ADDR_W-1:0]   waddr_q [FWD_STAGES];
    logic [REG_ADDR_W-1:0]   waddr_d [FWD_STAGES];
    logic [MD_W-1:0]         md_cnt_q, md_cnt_d;
    logic [31:0]             stall_cnt_q, stall_cnt_d;

    logic [NUM_RD_PORTS-1:0] load_use_port;
    logic                    load_use;
    logic                    accept;

    // Forwarding mux: walk oldest to youngest so the youngest match overrides; r0 is never forwarded.
    always_comb begin
        fwd_rdata     = rf_rdata;
        load_use_port = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int i = FWD_STAGES - 1; i >= 0; i--) begin
                if (v_q[i] && we_q[i]
                    && (waddr_q[i] == rd_addr[p*REG_ADDR_W +: REG_ADDR_W])
                    && (rd_addr[p*REG_ADDR_W +: REG_ADDR_W] != '0)) begin
                    fwd_rdata[p*DATA_W +: DATA_W] = stage_wdata[i*DATA_W +: DATA_W];
                    load_use_port[p] = load_q[i] && (i < LOAD_READY_STAGE);
                end
            end
        end
    end

    assign load_use  = issue_valid && (|load_use_port);
    assign md_busy   = (md_cnt_q != '0);
    assign freeze    = ext_hold || md_busy;
    assign stallreq  = load_use || freeze;
    assign bubble_ex = load_use && !freeze;
    // Flush only blocks acceptance; it never cancels a stall.
    assign accept    = issue_valid && !load_use && !flush && !freeze;
    assign stall_cnt = stall_cnt_q;

    // Next-state for records, mult/div counter and stall counter.
    always_comb begin
        v_d         = v_q;
        we_d        = we_q;
        load_d      = load_q;
        waddr_d     = waddr_q;
        md_cnt_d    = md_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (!freeze) begin
            for (int i = 1; i < FWD_STAGES; i++) begin
                v_d[i]     = v_q[i-1];
                we_d[i]    = we_q[i-1];
                load_d[i]  = load_q[i-1];
                waddr_d[i] = waddr_q[i-1];
            end
            v_d[0]     = accept;
            we_d[0]    = issue_we;
            load_d[0]  = issue_load;
            waddr_d[0] = issue_waddr;
        end

        // Counter runs down independently of ext_hold once started.
        if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end else if (accept && issue_md) begin
            md_cnt_d = MD_LOAD;
        end

        if (stallreq && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous reset; reset clears every pending record and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            we_q        <= '0;
            load_q      <= '0;
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < FWD_STAGES; i++) begin
                waddr_q[i] <= '0;
            end
        end else begin
            v_q         <= v_d;
            we_q        <= we_d;
            load_q      <= load_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < FWD_STAGES; i++) begin
                waddr_q[i] <= waddr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the live outputs.
module tb_hazard_scoreboard;

    localparam int DATA_W = 32;
    localparam int RAW    = 5;
    localparam int NRP    = 2;
    localparam int FWS    = 3;
    localparam int LRS    = 1;
    localparam int MDL    = 4;

    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_0001;

    localparam int S_FWD0 = 0;
    localparam int S_FWD1 = 1;
    localparam int S_STL  = 2;
    localparam int S_BUB  = 3;
    localparam int S_FRZ  = 4;
    localparam int S_MD   = 5;
    localparam int S_CNT  = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    issue_valid, issue_we, issue_load, issue_md;
    logic [RAW-1:0]          issue_waddr;
    logic                    flush, ext_hold;
    logic [NRP*RAW-1:0]      rd_addr;
    logic [NRP*DATA_W-1:0]   rf_rdata;
    logic [FWS*DATA_W-1:0]   stage_wdata;
    logic [NRP*DATA_W-1:0]   fwd_rdata;
    logic                    stallreq, bubble_ex, freeze, md_busy;
    logic [31:0]             stall_cnt;

    hazard_scoreboard #(
        .DATA_W(DATA_W), .REG_ADDR_W(RAW), .NUM_RD_PORTS(NRP),
        .FWD_STAGES(FWS), .LOAD_READY_STAGE(LRS), .MD_LAT(MDL)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_waddr(issue_waddr),
        .issue_load(issue_load), .issue_md(issue_md),
        .flush(flush), .ext_hold(ext_hold),
        .rd_addr(rd_addr), .rf_rdata(rf_rdata), .stage_wdata(stage_wdata),
        .fwd_rdata(fwd_rdata), .stallreq(stallreq), .bubble_ex(bubble_ex),
        .freeze(freeze), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_FWD0:  return fwd_rdata[31:0];
            S_FWD1:  return fwd_rdata[63:32];
            S_STL:   return {31'd0, stallreq};
            S_BUB:   return {31'd0, bubble_ex};
            S_FRZ:   return {31'd0, freeze};
            S_MD:    return {31'd0, md_busy};
            default: return stall_cnt;
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            checks++;
            if (a !== e.val) begin
                failures++;
                $display("FAIL %s (cycle %0d): got 0x%08h expected 0x%08h", e.name, cyc, a, e.val);
            end
        end
    end

    task automatic want(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic want_ctl(input string name, input logic s, input logic b,
                            input logic f, input logic m);
        want({name, "_stallreq"},  S_STL, {31'd0, s});
        want({name, "_bubble_ex"}, S_BUB, {31'd0, b});
        want({name, "_freeze"},    S_FRZ, {31'd0, f});
        want({name, "_md_busy"},   S_MD,  {31'd0, m});
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        issue_valid = 1'b0; issue_we = 1'b0; issue_waddr = '0;
        issue_load  = 1'b0; issue_md = 1'b0;
        flush = 1'b0; ext_hold = 1'b0;
        rd_addr = '0;
        stage_wdata = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            nxt();
            idle_in();
        end
    endtask

    task automatic issue(input logic we, input logic [RAW-1:0] wa,
                         input logic ld, input logic md);
        issue_valid = 1'b1; issue_we = we; issue_waddr = wa;
        issue_load  = ld;   issue_md = md;
    endtask

    task automatic set_rd(input logic [RAW-1:0] a0, input logic [RAW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_sw(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
        stage_wdata = {s2, s1, s0};
    endtask

    // Watchdog: the run must always terminate.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rf_rdata = {RF1, RF0};
        idle_in();
        rst = 1'b1;

        // Reset state
        nxt();
        nxt(); idle_in(); set_rd(5'd3, 5'd4); set_sw(32'h1, 32'h2, 32'h3);
        want("rst_fwd0", S_FWD0, RF0);
        want("rst_fwd1", S_FWD1, RF1);
        want_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        want("rst_cnt", S_CNT, 32'd0);
        nxt(); idle_in(); rst = 1'b0;

        // 1. EX-stage forward
        nxt(); idle_in(); issue(1'b1, 5'd8, 1'b0, 1'b0);
        nxt(); idle_in(); set_rd(5'd8, 5'd7); set_sw(32'h1234, 32'h5555, 32'h6666);
        want("t1_fwd0", S_FWD0, 32'h1234);
        want("t1_fwd1", S_FWD1, RF1);
        want("t1_stallreq", S_STL, 32'd0);
        idle_cycles(3);

        // 2. Youngest match wins; r0 is never forwarded
        nxt(); idle_in(); issue(1'b1, 5'd9, 1'b0, 1'b0);
        nxt(); idle_in(); issue(1'b1, 5'd0, 1'b0, 1'b0);
        nxt(); idle_in(); issue(1'b1, 5'd9, 1'b0, 1'b0);
        nxt(); idle_in(); set_rd(5'd9, 5'd0); set_sw(32'hA, 32'hB, 32'hC);
        want("t2_prio_fwd0", S_FWD0, 32'hA);
        want("t2_r0_fwd1", S_FWD1, RF1);
        want("t2_stallreq", S_STL, 32'd0);
        idle_cycles(3);

        // Flush prevents acceptance
        nxt(); idle_in(); issue(1'b1, 5'd12, 1'b0, 1'b0); flush = 1'b1;
        nxt(); idle_in(); set_rd(5'd12, 5'd0); set_sw(32'h77, 32'h78, 32'h79);
        want("flush_noaccept_fwd0", S_FWD0, RF0);
        idle_cycles(3);

        // 3. Load-use, with flush asserted during the stall
        nxt(); idle_in(); issue(1'b1, 5'd5, 1'b1, 1'b0);
        nxt(); idle_in(); issue(1'b1, 5'd6, 1'b0, 1'b0); flush = 1'b1;
        set_rd(5'd5, 5'd0); set_sw(32'h11, 32'h22, 32'h33);
        want_ctl("t3_lu", 1'b1, 1'b1, 1'b0, 1'b0);
        want("t3_lu_cnt", S_CNT, 32'd0);
        nxt(); idle_in(); issue(1'b1, 5'd6, 1'b0, 1'b0);
        set_rd(5'd5, 5'd0); set_sw(32'h11, 32'h22, 32'h33);
        want("t3_mem_fwd0", S_FWD0, 32'h22);
        want_ctl("t3_after", 1'b0, 1'b0, 1'b0, 1'b0);
        want("t3_after_cnt", S_CNT, 32'd1);
        idle_cycles(3);

        // 4. Mult/div busy for MD_LAT cycles, records frozen
        nxt(); idle_in(); issue(1'b1, 5'd4, 1'b0, 1'b1);
        want_ctl("t4_issue", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= MDL; k++) begin
            nxt(); idle_in(); set_rd(5'd4, 5'd0); set_sw(32'h44, 32'h45, 32'h46);
            want("t4_busy_fwd0", S_FWD0, 32'h44);
            want_ctl("t4_busy", 1'b1, 1'b0, 1'b1, 1'b1);
            want("t4_busy_cnt", S_CNT, 32'(k));
        end
        nxt(); idle_in(); set_rd(5'd4, 5'd0); set_sw(32'h44, 32'h45, 32'h46);
        want("t4_done_fwd0", S_FWD0, 32'h44);
        want_ctl("t4_done", 1'b0, 1'b0, 1'b0, 1'b0);
        want("t4_done_cnt", S_CNT, 32'd5);
        idle_cycles(3);

        // 5. ext_hold for 3 cycles; issue and flush ignored while held
        nxt(); idle_in(); issue(1'b1, 5'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            nxt(); idle_in(); ext_hold = 1'b1; issue(1'b1, 5'd13, 1'b0, 1'b0);
            flush = (k == 1);
            set_rd(5'd3, 5'd0); set_sw(32'h3333, 32'h9999, 32'h0);
            want("t5_hold_fwd0", S_FWD0, 32'h3333);
            want_ctl("t5_hold", 1'b1, 1'b0, 1'b1, 1'b0);
            want("t5_hold_cnt", S_CNT, 32'(5 + k));
        end
        nxt(); idle_in(); set_rd(5'd3, 5'd0); set_sw(32'h3333, 32'h9999, 32'h0);
        want("t5_release_fwd0", S_FWD0, 32'h3333);
        want_ctl("t5_release", 1'b0, 1'b0, 1'b0, 1'b0);
        want("t5_release_cnt", S_CNT, 32'd8);
        nxt(); idle_in(); set_rd(5'd3, 5'd13); set_sw(32'h3333, 32'h9999, 32'h0);
        want("t5_mem_fwd0", S_FWD0, 32'h9999);
        want("t5_heldissue_fwd1", S_FWD1, RF1);
        idle_cycles(3);

        // 6. Reset during md_busy with all stages valid
        nxt(); idle_in(); issue(1'b1, 5'd20, 1'b0, 1'b0);
        nxt(); idle_in(); issue(1'b1, 5'd21, 1'b0, 1'b0);
        nxt(); idle_in(); issue(1'b1, 5'd22, 1'b0, 1'b1);
        nxt(); idle_in(); rst = 1'b1; set_rd(5'd21, 5'd22); set_sw(32'hE0, 32'hE1, 32'hE2);
        want("t6_pre_fwd0", S_FWD0, 32'hE1);
        want("t6_pre_fwd1", S_FWD1, 32'hE0);
        want_ctl("t6_pre", 1'b1, 1'b0, 1'b1, 1'b1);
        want("t6_pre_cnt", S_CNT, 32'd8);
        nxt(); idle_in(); rst = 1'b0; set_rd(5'd21, 5'd22); set_sw(32'hE0, 32'hE1, 32'hE2);
        want("t6_post_fwd0", S_FWD0, RF0);
        want("t6_post_fwd1", S_FWD1, RF1);
        want_ctl("t6_post", 1'b0, 1'b0, 1'b0, 1'b0);
        want("t6_post_cnt", S_CNT, 32'd0);

        nxt(); idle_in();
        nxt();
        #6;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations never compared, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
